// File: rtl/fifo_frame_reader_pkg.sv
// ============================================================================
// Module      : fifo_frame_reader_pkg
// Description : Shared audio-stream constants and the frame-reader state type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_frame_reader_pkg;

    localparam int unsigned c_DEF_DATA_W    = 31;
    localparam int unsigned c_DEF_FRAME_LEN = 256;
    localparam int unsigned c_FRAME_CNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage : fifo_frame_reader_pkg

`default_nettype wire

// File: rtl/fifo_frame_reader_skid_buf.sv
// ============================================================================
// Module      : stream_skid_buf
// Description : Two-entry valid/ready buffer; reports occupancy for credit use.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf
    import fifo_frame_reader_pkg::*;
#(
    parameter int unsigned DATA_W = c_DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_s_valid,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_m_ready,
    output logic              o_m_valid,
    output logic [DATA_W-1:0] o_m_data,
    output logic [1:0]        o_occ
);

    logic [1:0]        r_occ;
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic              w_pop;
    logic              w_push;

    assign w_pop  = (r_occ != 2'd0) && i_m_ready;
    // A push into a full buffer is only legal when the head leaves this cycle.
    assign w_push = i_s_valid && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_s_data;
                    end else begin
                        r_tail <= i_s_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_head <= i_s_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_s_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_m_valid = (r_occ != 2'd0);
    assign o_m_data  = r_head;
    assign o_occ     = r_occ;

endmodule : stream_skid_buf

`default_nettype wire

// File: rtl/fifo_frame_reader.sv
// ============================================================================
// Module      : fifo_frame_reader
// Description : Bursts whole FRAME_LEN frames from the sample FIFO to a stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_frame_reader
    import fifo_frame_reader_pkg::*;
#(
    parameter int unsigned DATA_W    = c_DEF_DATA_W,
    parameter int unsigned LEVEL_W   = 10,
    parameter int unsigned FRAME_LEN = c_DEF_FRAME_LEN
) (
    input  logic                     sys_clk,
    input  logic                     sys_rstn,
    input  logic                     enable,
    output logic                     fifo_rd_en,
    input  logic [DATA_W-1:0]        fifo_rd_data,
    input  logic                     fifo_rd_empty,
    input  logic [LEVEL_W-1:0]       fifo_rd_level,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_sop,
    output logic                     m_eop,
    output logic                     busy,
    output logic                     underrun,
    input  logic                     clr_err,
    output logic [c_FRAME_CNT_W-1:0] frame_cnt
);

    localparam logic [LEVEL_W-1:0] c_LEN  = LEVEL_W'(FRAME_LEN);
    localparam logic [LEVEL_W-1:0] c_LAST = LEVEL_W'(FRAME_LEN - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [LEVEL_W-1:0]       r_req_cnt;
    logic [LEVEL_W-1:0]       r_out_cnt;
    logic                     r_inflight;
    logic                     r_underrun;
    logic [c_FRAME_CNT_W-1:0] r_frame_cnt;

    logic [1:0]               w_occ;
    logic [2:0]               w_pending;
    logic                     w_credit_ok;
    logic                     w_rd_en;
    logic                     w_xfer;
    logic                     w_last_xfer;
    logic                     w_under_set;

    stream_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (sys_clk),
        .rst_n     (sys_rstn),
        .i_s_valid (r_inflight),
        .i_s_data  (fifo_rd_data),
        .i_m_ready (m_ready),
        .o_m_valid (m_valid),
        .o_m_data  (m_data),
        .o_occ     (w_occ)
    );

    assign w_xfer      = m_valid && m_ready;
    assign m_sop       = m_valid && (r_out_cnt == '0);
    assign m_eop       = m_valid && (r_out_cnt == c_LAST);
    assign w_last_xfer = w_xfer && m_eop;

    // Credit counts the slot freed by a same-cycle transfer so a continuously
    // ready sink sees one word per cycle instead of every other cycle.
    assign w_pending   = 3'(w_occ) + 3'(r_inflight) - 3'(w_xfer);
    assign w_credit_ok = (w_pending < 3'd2);

    assign w_under_set = (r_state == ST_BURST) && (r_req_cnt < c_LEN) && fifo_rd_empty;

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && (fifo_rd_level >= c_LEN)) begin
                    w_next = ST_BURST;
                end
            end
            ST_BURST: begin
                w_rd_en = (r_req_cnt < c_LEN) && !fifo_rd_empty && w_credit_ok;
                if (w_rd_en && (r_req_cnt == c_LAST)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_last_xfer) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state    <= ST_IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_rd_en;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_req_cnt <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_last_xfer) begin
                r_req_cnt <= '0;
            end else if (w_rd_en) begin
                r_req_cnt <= r_req_cnt + LEVEL_W'(1);
            end

            if (w_last_xfer) begin
                r_out_cnt <= '0;
            end else if (w_xfer) begin
                r_out_cnt <= r_out_cnt + LEVEL_W'(1);
            end
        end
    end

    // A new underrun in the same cycle as clr_err must not be lost.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_underrun <= 1'b0;
        end else if (w_under_set) begin
            r_underrun <= 1'b1;
        end else if (clr_err) begin
            r_underrun <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_frame_cnt <= '0;
        end else if (w_last_xfer) begin
            r_frame_cnt <= r_frame_cnt + c_FRAME_CNT_W'(1);
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign busy       = (r_state != ST_IDLE);
    assign underrun   = r_underrun;
    assign frame_cnt  = r_frame_cnt;

endmodule : fifo_frame_reader

`default_nettype wire

// File: tb/tb_fifo_frame_reader.sv
// ============================================================================
// Module      : tb_fifo_frame_reader
// Description : Self-checking bench: FIFO model, stream scoreboard, directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fifo_frame_reader;

    localparam int unsigned DATA_W    = 31;
    localparam int unsigned LEVEL_W   = 10;
    localparam int unsigned FRAME_LEN = 256;

    logic               sys_clk = 1'b0;
    logic               sys_rstn = 1'b0;
    logic               enable = 1'b0;
    logic               fifo_rd_en;
    logic [DATA_W-1:0]  fifo_rd_data = '0;
    logic               fifo_rd_empty = 1'b1;
    logic [LEVEL_W-1:0] fifo_rd_level = '0;
    logic               m_valid;
    logic               m_ready = 1'b1;
    logic [DATA_W-1:0]  m_data;
    logic               m_sop;
    logic               m_eop;
    logic               busy;
    logic               underrun;
    logic               clr_err = 1'b0;
    logic [15:0]        frame_cnt;

    fifo_frame_reader #(
        .DATA_W    (DATA_W),
        .LEVEL_W   (LEVEL_W),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .enable        (enable),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_level (fifo_rd_level),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sop         (m_sop),
        .m_eop         (m_eop),
        .busy          (busy),
        .underrun      (underrun),
        .clr_err       (clr_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // FIFO contents, and words read out of the FIFO but not yet delivered.
    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] popped_q[$];

    int          vec_cnt = 0;
    int          err_cnt = 0;
    bit          force_empty = 1'b0;
    bit          rand_ready = 1'b0;
    bit          rd_fire = 1'b0;
    bit          any_rd = 1'b0;
    bit          eop_seen = 1'b0;
    int          k_idx = 0;
    logic [15:0] exp_fc = '0;
    int          cyc = 0;
    int          t_busy = -1;
    int          t_valid = -1;
    int          t_eop = -1;
    int          words_delivered = 0;
    bit          prev_stall = 1'b0;
    logic [DATA_W+1:0] prev_word = '0;

    typedef struct {
        int n_words;
        bit en;
        bit exp_busy;
    } start_vec_t;

    start_vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vec_cnt++;
        err_cnt++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic apply_flags();
        fifo_rd_level = (fifo_q.size() > 1023) ? LEVEL_W'(1023) : LEVEL_W'(fifo_q.size());
        fifo_rd_empty = (fifo_q.size() == 0) || force_empty;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(DATA_W'($urandom()));
        end
        apply_flags();
    endtask

    // Negedge observation: scoreboard, stall stability, read legality.
    task automatic monitor();
        logic [DATA_W-1:0] exp_w;
        cyc++;
        if (!sys_rstn) begin
            check("reset_outputs", 64'({fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun, frame_cnt}), 64'd0);
            popped_q.delete();
            k_idx      = 0;
            exp_fc     = '0;
            rd_fire    = 1'b0;
            prev_stall = 1'b0;
            return;
        end
        check("frame_cnt", 64'(frame_cnt), 64'(exp_fc));
        if (prev_stall) begin
            check("stall_hold", 64'({m_valid, m_sop, m_eop, m_data}), 64'({1'b1, prev_word}));
        end
        if (busy && t_busy < 0) t_busy = cyc;
        if (m_valid && t_valid < 0) t_valid = cyc;
        rd_fire = fifo_rd_en;
        if (fifo_rd_en) begin
            any_rd = 1'b1;
            check("rd_while_empty", 64'(fifo_rd_empty), 64'd0);
        end
        if (m_valid && m_ready) begin
            if (popped_q.size() == 0) begin
                fail_now("word_not_read_from_fifo");
            end else begin
                exp_w = popped_q.pop_front();
                check("data", 64'(m_data), 64'(exp_w));
                check("sop", 64'(m_sop), 64'(k_idx == 0));
                check("eop", 64'(m_eop), 64'(k_idx == FRAME_LEN - 1));
            end
            words_delivered++;
            if (k_idx == FRAME_LEN - 1) begin
                k_idx    = 0;
                exp_fc   = exp_fc + 16'd1;
                eop_seen = 1'b1;
                t_eop    = cyc;
            end else begin
                k_idx++;
            end
        end
        if (rd_fire) begin
            check("outstanding_le2", 64'(popped_q.size() < 2), 64'd1);
        end
        prev_stall = m_valid && !m_ready;
        prev_word  = {m_sop, m_eop, m_data};
    endtask

    // Posedge+1 action of the FIFO: one-cycle read latency.
    task automatic fifo_update();
        logic [DATA_W-1:0] w;
        if (rd_fire && sys_rstn) begin
            if (fifo_q.size() == 0) begin
                fail_now("read_of_empty_model_fifo");
            end else begin
                w = fifo_q.pop_front();
                fifo_rd_data = w;
                popped_q.push_back(w);
            end
        end
        rd_fire = 1'b0;
        apply_flags();
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic step();
        @(negedge sys_clk);
        monitor();
        @(posedge sys_clk);
        #1;
        fifo_update();
    endtask

    task automatic run_frame();
        eop_seen = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (eop_seen) break;
        end
        if (!eop_seen) fail_now("timeout_waiting_for_eop");
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 4000; i++) begin
            if (k_idx >= n) return;
            step();
        end
        fail_now("timeout_waiting_for_words");
    endtask

    initial begin
        tbl[0] = '{255, 1'b1, 1'b0};
        tbl[1] = '{256, 1'b0, 1'b0};
        tbl[2] = '{256, 1'b1, 1'b1};
        tbl[3] = '{0,   1'b1, 1'b0};
        tbl[4] = '{300, 1'b1, 1'b1};
        tbl[5] = '{1100, 1'b1, 1'b1};

        for (int i = 0; i < 3; i++) step();
        sys_rstn = 1'b1;
        step();

        // Start-condition table with m_ready held high.
        for (int v = 0; v < 6; v++) begin
            fifo_q.delete();
            enable = 1'b0;
            apply_flags();
            step();
            step();
            t_busy = -1;
            t_valid = -1;
            any_rd = 1'b0;
            words_delivered = 0;
            fill(tbl[v].n_words);
            enable = tbl[v].en;
            for (int j = 0; j < 6; j++) step();
            check($sformatf("start_busy_v%0d", v), 64'(busy), 64'(tbl[v].exp_busy));
            check($sformatf("start_rd_v%0d", v), 64'(any_rd), 64'(tbl[v].exp_busy));
            if (tbl[v].exp_busy) begin
                check("first_valid_latency", 64'(t_valid - t_busy), 64'd2);
                enable = 1'b0;
                run_frame();
                check("burst_span", 64'(t_eop - t_valid + 1), 64'(FRAME_LEN));
                check("frame_words", 64'(words_delivered), 64'(FRAME_LEN));
            end
        end
        check("frame_cnt_after_table", 64'(frame_cnt), 64'd3);

        // Back-to-back frames: IDLE must appear between them.
        fifo_q.delete();
        fill(2 * FRAME_LEN);
        enable = 1'b1;
        run_frame();
        check("idle_gap_busy", 64'(busy), 64'd0);
        run_frame();
        enable = 1'b0;

        // Random 50% backpressure, enable dropped mid-frame.
        fill(FRAME_LEN);
        rand_ready = 1'b1;
        words_delivered = 0;
        enable = 1'b1;
        for (int j = 0; j < 4; j++) step();
        enable = 1'b0;
        run_frame();
        rand_ready = 1'b0;
        m_ready = 1'b1;
        check("random_ready_words", 64'(words_delivered), 64'(FRAME_LEN));

        // Underrun: FIFO forced empty for 5 cycles after word 100.
        fill(FRAME_LEN);
        words_delivered = 0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_words(100);
        force_empty = 1'b1;
        apply_flags();
        for (int j = 0; j < 5; j++) begin
            clr_err = (j == 2);
            step();
        end
        clr_err = 1'b0;
        check("underrun_set_wins", 64'(underrun), 64'd1);
        check("no_read_while_empty", 64'(fifo_rd_en), 64'd0);
        force_empty = 1'b0;
        apply_flags();
        run_frame();
        check("underrun_words", 64'(words_delivered), 64'(FRAME_LEN));
        check("underrun_sticky", 64'(underrun), 64'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("underrun_cleared", 64'(underrun), 64'd0);

        // Asynchronous reset at word 50 of a burst.
        fill(FRAME_LEN);
        enable = 1'b1;
        step();
        enable = 1'b0;
        wait_words(50);
        #2;
        sys_rstn = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({fifo_rd_en, m_valid, m_sop, m_eop, busy, underrun, frame_cnt}), 64'd0);
        for (int j = 0; j < 3; j++) step();
        sys_rstn = 1'b1;
        step();
        check("frame_cnt_after_reset", 64'(frame_cnt), 64'd0);
        fill(FRAME_LEN);
        words_delivered = 0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_frame();
        check("post_reset_words", 64'(words_delivered), 64'(FRAME_LEN));
        step();
        check("post_reset_frame_cnt", 64'(frame_cnt), 64'd1);

        // frame_cnt wrap from 65535.
        force dut.r_frame_cnt = 16'hFFFF;
        exp_fc = 16'hFFFF;
        step();
        release dut.r_frame_cnt;
        step();
        check("frame_cnt_preset", 64'(frame_cnt), 64'hFFFF);
        fill(FRAME_LEN);
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_frame();
        step();
        check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_fifo_frame_reader

`default_nettype wire
